// File: rtl/alu_regfile_sequencer.sv
// ============================================================================
// Module   : alu_regfile_sequencer
// Purpose  : 8-entry register file and operand/writeback sequencer wrapped
//            around an external 16-bit combinational ALU; 4 cycles/instruction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_regfile_sequencer #(
  parameter int NBIT = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            instr_ld,
  input  logic [2:0]      instr_fs,
  input  logic [AW-1:0]   instr_rd,
  input  logic [AW-1:0]   instr_ra,
  input  logic [AW-1:0]   instr_rb,
  input  logic [NBIT-1:0] instr_imm,
  output logic [2:0]      alu_fs,
  output logic [NBIT-1:0] alu_a,
  output logic [NBIT-1:0] alu_b,
  input  logic [NBIT-1:0] alu_out,
  input  logic            alu_zero,
  output logic            wb_done,
  output logic [NBIT-1:0] wb_data,
  output logic            zero_reg,
  input  logic [AW-1:0]   dbg_addr,
  output logic [NBIT-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [NBIT-1:0] r_regs [NREG];
  logic            r_ld;
  logic [2:0]      r_fs;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_ra;
  logic [AW-1:0]   r_rb;
  logic [NBIT-1:0] r_imm;
  logic [2:0]      r_alu_fs;
  logic [NBIT-1:0] r_alu_a;
  logic [NBIT-1:0] r_alu_b;
  logic [NBIT-1:0] r_result;
  logic            r_wb_done;
  logic            r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ:  w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ALU operand registers are only loaded in READ, so they hold across IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_ld      <= 1'b0;
      r_fs      <= '0;
      r_rd      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_imm     <= '0;
      r_alu_fs  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_result  <= '0;
      r_wb_done <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_wb_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_ld  <= instr_ld;
            r_fs  <= instr_fs;
            r_rd  <= instr_rd;
            r_ra  <= instr_ra;
            r_rb  <= instr_rb;
            r_imm <= instr_imm;
          end
        end
        S_READ: begin
          r_alu_a  <= r_regs[r_ra];
          r_alu_b  <= r_regs[r_rb];
          r_alu_fs <= r_fs;
        end
        S_EXEC: begin
          r_result  <= r_ld ? r_imm : alu_out;
          if (!r_ld) begin
            r_zero <= alu_zero;
          end
          r_wb_done <= 1'b1;
        end
        S_WB: begin
          // Register 0 is hardwired to zero; its writes are dropped here.
          if (r_rd != '0) begin
            r_regs[r_rd] <= r_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_fs   = r_alu_fs;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign wb_done  = r_wb_done;
  assign wb_data  = r_result;
  assign zero_reg = r_zero;
  assign dbg_data = r_regs[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_alu_regfile_sequencer.sv
// ============================================================================
// Module   : tb_alu_regfile_sequencer
// Purpose  : Self-checking bench: instruction table plus scoreboard on writeback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        instr_ld = 1'b0;
  logic [2:0]  instr_fs = '0;
  logic [2:0]  instr_rd = '0;
  logic [2:0]  instr_ra = '0;
  logic [2:0]  instr_rb = '0;
  logic [15:0] instr_imm = '0;
  logic [2:0]  alu_fs;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        wb_done;
  logic [15:0] wb_data;
  logic        zero_reg;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  alu_regfile_sequencer #(.NBIT(16), .NREG(8), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_ld(instr_ld), .instr_fs(instr_fs), .instr_rd(instr_rd),
    .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_imm(instr_imm),
    .alu_fs(alu_fs), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .wb_done(wb_done), .wb_data(wb_data), .zero_reg(zero_reg),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU feeding the DUT.
  always_comb begin
    alu_out = 16'h0000;
    case (alu_fs)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b110:  alu_out = alu_a & alu_b;
      3'b111:  alu_out = alu_a | alu_b;
      3'b100:  alu_out = alu_a ^ alu_b;
      3'b101:  alu_out = ~alu_a;
      default: alu_out = 16'h0000;
    endcase
    alu_zero = (alu_out == 16'h0000);
  end

  typedef struct {
    logic        ld;
    logic [2:0]  fs;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] imm;
    logic [15:0] exp_wb;
    logic        exp_zero;
    logic [15:0] exp_dbg;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        zero;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[11];
  logic [15:0] m_regs[8];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every writeback pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && wb_done) begin
      if (sb.size() == 0) begin
        check("unexpected_wb", 32'(wb_done), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_data", 32'(wb_data), 32'(e.data));
        check("zero_reg", 32'(zero_reg), 32'(e.zero));
      end
    end
  end

  task automatic issue(input vec_t v);
    int guard;
    int lat;
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_issue", 32'(instr_ready), 32'(1));
    instr_ld    = v.ld;
    instr_fs    = v.fs;
    instr_rd    = v.rd;
    instr_ra    = v.ra;
    instr_rb    = v.rb;
    instr_imm   = v.imm;
    instr_valid = 1'b1;
    sb.push_back('{data: v.exp_wb, zero: v.exp_zero});
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wb_done && lat < 10);
    check("wb_latency", 32'(lat), 32'(3));
    dbg_addr = v.rd;
    #1 check("dbg_during_wb", 32'(dbg_data), 32'(m_regs[v.rd]));
    @(negedge clk);
    check("dbg_after_wb", 32'(dbg_data), 32'(v.exp_dbg));
    check("ready_after_wb", 32'(instr_ready), 32'(1));
    m_regs[v.rd] = v.exp_dbg;
  endtask

  task automatic check_all_clear(input string tag);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1 check({tag, "_reg"}, 32'(dbg_data), 32'(0));
      m_regs[r] = 16'h0000;
    end
    check({tag, "_zero_reg"}, 32'(zero_reg), 32'(0));
    check({tag, "_wb_done"}, 32'(wb_done), 32'(0));
    check({tag, "_ready"}, 32'(instr_ready), 32'(1));
  endtask

  initial begin
    //          ld    fs      rd    ra    rb    imm       wb        z     dbg
    vecs[0]  = '{1'b1, 3'b000, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0005, 1'b0, 16'h0005};
    vecs[1]  = '{1'b1, 3'b000, 3'd2, 3'd0, 3'd0, 16'h0003, 16'h0003, 1'b0, 16'h0003};
    vecs[2]  = '{1'b0, 3'b000, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h0008, 1'b0, 16'h0008};
    vecs[3]  = '{1'b0, 3'b001, 3'd4, 3'd1, 3'd1, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    vecs[4]  = '{1'b0, 3'b101, 3'd5, 3'd1, 3'd0, 16'h0000, 16'hFFFA, 1'b0, 16'hFFFA};
    vecs[5]  = '{1'b0, 3'b111, 3'd0, 3'd1, 3'd2, 16'h0000, 16'h0007, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 3'b000, 3'd6, 3'd0, 3'd2, 16'h0000, 16'h0003, 1'b0, 16'h0003};
    vecs[7]  = '{1'b0, 3'b110, 3'd1, 3'd1, 3'd2, 16'h0000, 16'h0001, 1'b0, 16'h0001};
    vecs[8]  = '{1'b0, 3'b100, 3'd2, 3'd2, 3'd2, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    vecs[9]  = '{1'b1, 3'b000, 3'd7, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 3'b000, 3'd7, 3'd5, 3'd5, 16'h0000, 16'hFFF4, 1'b0, 16'hFFF4};
    for (int r = 0; r < 8; r++) m_regs[r] = 16'h0000;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_clear("reset");
    check("reset_alu_a", 32'(alu_a), 32'(0));
    check("reset_alu_b", 32'(alu_b), 32'(0));
    check("reset_alu_fs", 32'(alu_fs), 32'(0));

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i]);
    end
    check("idle_hold_alu_a", 32'(alu_a), 32'(16'hFFFA));
    check("idle_hold_alu_fs", 32'(alu_fs), 32'(3'b000));

    // Valid held high: accepted once every 4 cycles. R1=1, R6=3 -> R3=4.
    for (int k = 0; k < 3; k++) sb.push_back('{data: 16'h0004, zero: 1'b0});
    instr_ld = 1'b0; instr_fs = 3'b000; instr_rd = 3'd3;
    instr_ra = 3'd1; instr_rb = 3'd6; instr_imm = 16'h0000;
    instr_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("held_valid_ready", 32'(instr_ready), 32'((k % 4) == 0));
      @(negedge clk);
      if (k == 8) instr_valid = 1'b0;
    end
    repeat (4) @(negedge clk);
    m_regs[3] = 16'h0004;
    dbg_addr = 3'd3;
    #1 check("held_valid_r3", 32'(dbg_data), 32'(16'h0004));

    // Valid pulsed while busy must be ignored. R1+R1 = 2 into R5.
    sb.push_back('{data: 16'h0002, zero: 1'b0});
    instr_fs = 3'b000; instr_rd = 3'd5; instr_ra = 3'd1; instr_rb = 3'd1;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    instr_ld = 1'b1; instr_rd = 3'd4; instr_imm = 16'hBEEF; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; instr_ld = 1'b0;
    repeat (6) @(negedge clk);
    dbg_addr = 3'd4;
    #1 check("busy_valid_r4", 32'(dbg_data), 32'(16'h0000));
    dbg_addr = 3'd5;
    #1 check("busy_valid_r5", 32'(dbg_data), 32'(16'h0002));
    check("busy_valid_sb_empty", 32'(sb.size()), 32'(0));

    // Reset during EXEC aborts the load of R7.
    instr_ld = 1'b1; instr_rd = 3'd7; instr_imm = 16'h1234; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0; instr_ld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("abort_wb_done", 32'(wb_done), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_clear("abort");
    repeat (4) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/alu_regfile_sequencer.md
Name: alu_regfile_sequencer

Overview:
- Operand/writeback stage wrapped around the 16-bit combinational ALU.
- Holds an 8-entry register file and accepts one instruction at a time over a valid/ready handshake.
- Registers the selected operands and function select into the ALU, then captures the ALU result and zero flag and writes the result back to the destination register.
- Fixed 4-cycle sequence per instruction; no overlap, so no hazard/forwarding logic is needed.

Parameters:
- NBIT, 16, datapath width; must match ALU width.
- NREG, 8, number of registers.
- AW, 3, register address width; NREG = 2**AW.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  block can accept; high only in IDLE.
- instr_ld  input  1  1 = load immediate (ALU bypassed); 0 = ALU operation.
- instr_fs  input  3  ALU function: 000 add, 001 sub, 110 and, 111 or, 100 xor, 101 not A.
- instr_rd  input  AW  destination register.
- instr_ra  input  AW  operand A register.
- instr_rb  input  AW  operand B register.
- instr_imm  input  NBIT  immediate; used only when instr_ld=1.
- alu_fs  output  3  registered function select to ALU.
- alu_a  output  NBIT  registered operand A to ALU.
- alu_b  output  NBIT  registered operand B to ALU.
- alu_out  input  NBIT  ALU result (combinational from alu_fs/alu_a/alu_b).
- alu_zero  input  1  ALU zero flag.
- wb_done  output  1  one-cycle pulse: writeback occurs at the end of this cycle.
- wb_data  output  NBIT  value being written back; valid while wb_done=1.
- zero_reg  output  1  sticky zero flag of the last completed ALU operation.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  NBIT  combinational read of reg[dbg_addr].

Behaviour:
- Reset (asynchronous, immediate):
  - All registers clear to 0.
  - State goes to IDLE.
  - alu_fs, alu_a, alu_b, wb_data, result register, captured fields clear to 0.
  - wb_done and zero_reg clear to 0.
  - instr_ready=1 from the first cycle after reset deassertion.
- FSM states are IDLE, READ, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On an edge with instr_valid=1, capture ld/fs/rd/ra/rb/imm and go to READ.
  - Otherwise stay in IDLE.
- READ (instr_ready=0):
  - At the edge: alu_a <= reg[ra], alu_b <= reg[rb], alu_fs <= fs.
  - Go to EXEC.
- EXEC:
  - ALU output settles combinationally during this cycle.
  - At the edge: result <= (ld ? imm : alu_out).
  - If ld=0, zero_reg <= alu_zero; if ld=1, zero_reg is unchanged.
  - Set wb_done <= 1; go to WB.
- WB:
  - wb_done=1 and wb_data=result for exactly this cycle.
  - At the edge: reg[rd] <= result (unless rd=0), wb_done <= 0, go to IDLE.
- Latency and throughput:
  - Accept at edge E0; operands at ALU after E1; result captured at E2; wb_done high between E2 and E3; register updated at E3.
  - instr_ready is high again after E3.
  - Maximum rate is 1 instruction per 4 cycles.
- Register 0 always reads 0; writes to it are discarded, but wb_done still pulses and zero_reg still updates.
- instr_valid while instr_ready=0 is ignored; no capture, no queueing. The source must hold the instruction until it sees ready.
- Any of ra, rb, rd may be equal, including rd=ra. The read in READ sees the pre-instruction value.
- dbg_data reflects a write only after the WB edge, never during the WB cycle.
- Reset asserted in READ, EXEC or WB aborts the instruction: no write occurs and all registers are 0.
- alu_a/alu_b/alu_fs hold their last values in IDLE; they do not return to 0.
- Arithmetic overflow and wrap are the ALU's responsibility. This block passes NBIT bits unmodified.

Test Plan:
- Reset: assert rst mid-idle -> all dbg_data reads 0, zero_reg=0, wb_done=0, instr_ready=1 after release.
- Load then add:
  - ld R1=0x0005, then ld R2=0x0003 -> each shows a wb_done pulse exactly 3 cycles after accept, with wb_data equal to the immediate; zero_reg stays 0.
  - Then fs=000 rd=3 ra=1 rb=2 -> wb_data=0x0008, dbg R3=0x0008 after the WB edge, zero_reg=0.
- Subtract to zero: fs=001 rd=4 ra=1 rb=1 -> wb_data=0x0000, zero_reg=1. Follow with fs=101 rd=5 ra=1 -> R5=0xFFFA, zero_reg=0.
- Register 0: fs=111 rd=0 ra=1 rb=2 -> wb_done pulses with wb_data=0x0007, but dbg R0 stays 0x0000. Then add rd=6 ra=0 rb=2 -> R6=0x0003.
- Handshake:
  - Hold instr_valid=1 continuously with the same add instruction -> accepted once every 4 cycles, instr_ready low for 3 cycles between acceptances.
  - Valid pulsed while busy -> no extra writeback.
- Reset mid-operation: accept ld R7=0x1234, assert rst during EXEC -> no wb_done, R7=0, state IDLE and ready=1 after release.
